alu_mem_regfile: RTL and testbench

ALU_MEM_REGFILE -- requirements
Module: alu_mem_regfile

---
 rtl/yascm_pkg.sv | 22 ++
 rtl/alu.sv | 36 +++
 rtl/mem.sv | 29 ++
 rtl/regfile.sv | 32 +++
 rtl/alu_mem_regfile.sv | 55 +++++
 tb/tb_alu_mem_regfile.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/yascm_pkg.sv
// Shared definitions: data width, register count and ALU operation encodings.
package yascm_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int RAW   = $clog2(NREGS);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unused opcodes 11-15 produce zero.
module alu
  import yascm_pkg::*;
(
  input  logic [XLEN-1:0] alu_A,
  input  logic [XLEN-1:0] alu_B,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_result,
  output logic            alu_zero
);

  logic [4:0] shamt;
  assign shamt = alu_B[4:0];

  // Operation select; add/sub simply wrap, no carry is exported.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = alu_A + alu_B;
      ALU_SUB:  alu_result = alu_A - alu_B;
      ALU_AND:  alu_result = alu_A & alu_B;
      ALU_OR:   alu_result = alu_A | alu_B;
      ALU_XOR:  alu_result = alu_A ^ alu_B;
      ALU_NOR:  alu_result = ~(alu_A | alu_B);
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(alu_A) < $signed(alu_B))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (alu_A < alu_B)};
      ALU_SLL:  alu_result = alu_A << shamt;
      ALU_SRL:  alu_result = alu_A >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(alu_A) >>> shamt);
      default:  alu_result = '0;
    endcase
  end

  assign alu_zero = (alu_result == '0);

endmodule

// File: rtl/mem.sv
// Word-addressed data memory with asynchronous read; not cleared by reset.
module mem
  import yascm_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic            clk,
  input  logic [31:0]     mem_addr,
  input  logic [XLEN-1:0] mem_data_i,
  input  logic            mem_wen,
  output logic [XLEN-1:0] mem_data_o
);

  localparam int AW = $clog2(MEM_WORDS);

  // Byte offset and upper address bits are dropped, so addresses wrap.
  logic [AW-1:0] index;
  assign index = mem_addr[AW+1:2];

  logic [XLEN-1:0] words_q [MEM_WORDS] = '{default: '0};

  // Full-word write port.
  always_ff @(posedge clk) begin
    if (mem_wen) words_q[index] <= mem_data_i;
  end

  assign mem_data_o = words_q[index];

endmodule

// File: rtl/regfile.sv
// 32x32 register file, two asynchronous read ports, one write port, r0 hardwired to zero.
module regfile
  import yascm_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [RAW-1:0]  regA_addr,
  input  logic [RAW-1:0]  regB_addr,
  input  logic [RAW-1:0]  regC_addr,
  input  logic [XLEN-1:0] regC,
  input  logic            reg_wen,
  output logic [XLEN-1:0] regA,
  output logic [XLEN-1:0] regB
);

  // Entry 0 exists but is never written, so it stays at its reset value of zero.
  logic [XLEN-1:0] regs_q [NREGS];

  // Write port; reset clears everything and takes priority over writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (reg_wen && (regC_addr != '0)) begin
      regs_q[regC_addr] <= regC;
    end
  end

  // Reads see stored contents only: no write-through bypass.
  assign regA = (regA_addr == '0) ? '0 : regs_q[regA_addr];
  assign regB = (regB_addr == '0) ? '0 : regs_q[regB_addr];

endmodule

// File: rtl/alu_mem_regfile.sv
// Top level: ALU, register file and data memory side by side, ports passed straight through.
module alu_mem_regfile
  import yascm_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      regA_addr,
  input  logic [4:0]      regB_addr,
  input  logic [4:0]      regC_addr,
  input  logic [31:0]     regC,
  input  logic            reg_wen,
  output logic [31:0]     regA,
  output logic [31:0]     regB,
  input  logic [31:0]     alu_A,
  input  logic [31:0]     alu_B,
  input  logic [3:0]      alu_op,
  output logic [31:0]     alu_result,
  output logic            alu_zero,
  input  logic [31:0]     mem_addr,
  input  logic [31:0]     mem_data_i,
  input  logic            mem_wen,
  output logic [31:0]     mem_data_o
);

  alu u_alu (
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .regA_addr (regA_addr),
    .regB_addr (regB_addr),
    .regC_addr (regC_addr),
    .regC      (regC),
    .reg_wen   (reg_wen),
    .regA      (regA),
    .regB      (regB)
  );

  mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
    .clk        (clk),
    .mem_addr   (mem_addr),
    .mem_data_i (mem_data_i),
    .mem_wen    (mem_wen),
    .mem_data_o (mem_data_o)
  );

endmodule

// File: tb/tb_alu_mem_regfile.sv
// Directed bench: expected values pushed to a queue at drive time, popped at each sample point.
module tb_alu_mem_regfile;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  regA_addr, regB_addr, regC_addr;
  logic [31:0] regC;
  logic        reg_wen;
  logic [31:0] regA, regB;
  logic [31:0] alu_A, alu_B;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_addr, mem_data_i;
  logic        mem_wen;
  logic [31:0] mem_data_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  alu_mem_regfile #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .regA_addr  (regA_addr),
    .regB_addr  (regB_addr),
    .regC_addr  (regC_addr),
    .regC       (regC),
    .reg_wen    (reg_wen),
    .regA       (regA),
    .regB       (regB),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .mem_addr   (mem_addr),
    .mem_data_i (mem_data_i),
    .mem_wen    (mem_wen),
    .mem_data_o (mem_data_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        $error("%s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } alu_vec_t;

  alu_vec_t vecs[$];

  initial begin
    rst = 1'b1; reg_wen = 1'b0; mem_wen = 1'b0;
    regA_addr = 5'd1; regB_addr = 5'd31; regC_addr = '0; regC = '0;
    alu_A = '0; alu_B = '0; alu_op = '0;
    mem_addr = '0; mem_data_i = '0;

    // Reset state
    #3;
    expect_val(32'h0); check("reset_regA", regA);
    expect_val(32'h0); check("reset_regB", regB);
    expect_val(32'h0); check("mem_init", mem_data_o);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ALU table
    vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h1,  32'h0});
    vecs.push_back('{4'd1,  32'h5,         32'h7,  32'hFFFF_FFFE});
    vecs.push_back('{4'd6,  32'hFFFF_FFFF, 32'h1,  32'h1});
    vecs.push_back('{4'd7,  32'hFFFF_FFFF, 32'h1,  32'h0});
    vecs.push_back('{4'd10, 32'h8000_0000, 32'h4,  32'hF800_0000});
    vecs.push_back('{4'd9,  32'h8000_0000, 32'h4,  32'h0800_0000});
    vecs.push_back('{4'd8,  32'h1,         32'd35, 32'h8});
    vecs.push_back('{4'd2,  32'hF0F0,      32'hFF00, 32'hF000});
    vecs.push_back('{4'd3,  32'hF0F0,      32'hFF00, 32'hFFF0});
    vecs.push_back('{4'd4,  32'hF0F0,      32'hFF00, 32'h0FF0});
    vecs.push_back('{4'd5,  32'h0,         32'h0,  32'hFFFF_FFFF});
    vecs.push_back('{4'd0,  32'h7FFF_FFFF, 32'h1,  32'h8000_0000});
    vecs.push_back('{4'd12, 32'h5,         32'h3,  32'h0});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0});
    foreach (vecs[i]) begin
      alu_op = vecs[i].op; alu_A = vecs[i].a; alu_B = vecs[i].b;
      #1;
      expect_val(vecs[i].r);
      check($sformatf("alu_op%0d_result", vecs[i].op), alu_result);
      expect_val({31'b0, (vecs[i].r == 32'h0)});
      check($sformatf("alu_op%0d_zero", vecs[i].op), {31'b0, alu_zero});
    end

    // Register write r5, then r0 write ignored
    @(negedge clk);
    reg_wen = 1'b1; regC_addr = 5'd5; regC = 32'h1234_5678;
    @(negedge clk);
    regC_addr = 5'd0; regC = 32'hDEAD_BEEF;
    regA_addr = 5'd5; regB_addr = 5'd5;
    #1;
    expect_val(32'h1234_5678); check("r5_portA", regA);
    expect_val(32'h1234_5678); check("r5_portB_same", regB);
    @(negedge clk);
    reg_wen = 1'b0;
    regA_addr = 5'd0;
    #1;
    expect_val(32'h0); check("r0_ignored", regA);

    // Same-cycle read/write of r7: old value before edge, new after
    regB_addr = 5'd7; regA_addr = 5'd7;
    reg_wen = 1'b1; regC_addr = 5'd7; regC = 32'hA5A5_A5A5;
    #1;
    expect_val(32'h0); check("r7_before_edge", regB);
    @(posedge clk); #1;
    reg_wen = 1'b0;
    expect_val(32'hA5A5_A5A5); check("r7_after_edge_B", regB);
    expect_val(32'hA5A5_A5A5); check("r7_after_edge_A", regA);

    // X write enable must not modify r5
    @(negedge clk);
    reg_wen = 1'bx; regC_addr = 5'd5; regC = 32'h0;
    @(negedge clk);
    reg_wen = 1'b0; regA_addr = 5'd5;
    #1;
    expect_val(32'h1234_5678); check("r5_xwen_hold", regA);

    // Memory write / read with byte offset and wrap
    mem_addr = 32'h10; mem_data_i = 32'hCAFE_BABE; mem_wen = 1'b1;
    #1;
    expect_val(32'h0); check("mem_before_edge", mem_data_o);
    @(posedge clk); #1;
    mem_wen = 1'b0;
    expect_val(32'hCAFE_BABE); check("mem_after_edge", mem_data_o);
    mem_addr = 32'h13; #1;
    expect_val(32'hCAFE_BABE); check("mem_byte_offset", mem_data_o);
    mem_addr = 32'h10 + MEM_WORDS * 4; #1;
    expect_val(32'hCAFE_BABE); check("mem_wrap", mem_data_o);
    mem_addr = 32'h14; #1;
    expect_val(32'h0); check("mem_neighbor", mem_data_o);
    mem_addr = 32'h0C; #1;
    expect_val(32'h0); check("mem_neighbor_low", mem_data_o);

    // Reset mid-operation
    @(negedge clk);
    reg_wen = 1'b1; regC_addr = 5'd3; regC = 32'h11;
    @(negedge clk);
    reg_wen = 1'b0; regA_addr = 5'd3; mem_addr = 32'h10;
    #1;
    expect_val(32'h11); check("r3_written", regA);
    #1 rst = 1'b1;
    #1;
    expect_val(32'h0); check("r3_async_reset", regA);
    regB_addr = 5'd5; #1;
    expect_val(32'h0); check("r5_async_reset", regB);
    expect_val(32'hCAFE_BABE); check("mem_survives_reset", mem_data_o);
    reg_wen = 1'b1; regC_addr = 5'd4; regC = 32'h4444;
    @(posedge clk); #1;
    regA_addr = 5'd4;
    #1;
    expect_val(32'h0); check("write_blocked_in_reset", regA);
    @(negedge clk);
    reg_wen = 1'b0; rst = 1'b0;
    #1;
    expect_val(32'h0); check("r4_after_reset", regA);

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
